// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point operand front-end.
//   - one-hot class bit indices and class vector width
//   - FSM state encoding for the unpack/normalise block
//   - helper for the all-ones (inf/NaN) exponent pattern
package fp_pkg;

  // Class vector is {zero, subnormal, normal, inf, qnan, snan}, zero in the MSB.
  localparam int unsigned CLS_W      = 6;
  localparam int unsigned CLS_SNAN   = 0;
  localparam int unsigned CLS_QNAN   = 1;
  localparam int unsigned CLS_INF    = 2;
  localparam int unsigned CLS_NORMAL = 3;
  localparam int unsigned CLS_SUB    = 4;
  localparam int unsigned CLS_ZERO   = 5;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StHold
  } norm_state_e;

  // All-ones exponent value for a field of the given width (widths up to 31 bits).
  function automatic int unsigned exp_ones(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational field split and classification of one packed FP operand.
//   flp_i   : packed operand {sign, exponent, fraction}
//   sign_o  : sign bit
//   exp_o   : raw exponent field
//   frac_o  : raw fraction field
//   cls_o   : one-hot class {zero, subnormal, normal, inf, qnan, snan}
module fp_classify
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] flp_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W-1:0]     frac_o,
  output logic [CLS_W-1:0]     cls_o
);

  localparam logic [EXP_W-1:0] ExpOnes = EXP_W'(exp_ones(EXP_W));

  logic exp_zero;
  logic exp_max;
  logic frac_zero;

  assign sign_o    = flp_i[EXP_W+MAN_W];
  assign exp_o     = flp_i[EXP_W+MAN_W-1:MAN_W];
  assign frac_o    = flp_i[MAN_W-1:0];
  assign exp_zero  = (exp_o == '0);
  assign exp_max   = (exp_o == ExpOnes);
  assign frac_zero = (frac_o == '0);

  always_comb begin
    cls_o = '0;
    if (exp_zero) begin
      if (frac_zero) cls_o[CLS_ZERO] = 1'b1;
      else           cls_o[CLS_SUB]  = 1'b1;
    end else if (!exp_max) begin
      cls_o[CLS_NORMAL] = 1'b1;
    end else if (frac_zero) begin
      cls_o[CLS_INF] = 1'b1;
    end else if (frac_o[MAN_W-1]) begin
      cls_o[CLS_QNAN] = 1'b1;
    end else begin
      cls_o[CLS_SNAN] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_unpack_norm.sv
// Handshaked operand front-end: unpacks and classifies two FP operands, restores
// the hidden bit and normalises subnormal significands one bit per cycle.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake for the operand pair flp_a / flp_b
//   out_valid / out_ready : output handshake for the normalised pair
//   sign_*, exp_*, sig_*  : sign, signed biased exponent (EXP_W+2), significand
//                           with explicit hidden bit (MAN_W+1)
//   cls_*                 : original one-hot class of each operand
module fp_unpack_norm
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] flp_a,
  input  logic [EXP_W+MAN_W:0] flp_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sign_a,
  output logic                 sign_b,
  output logic [EXP_W+1:0]     exp_a,
  output logic [EXP_W+1:0]     exp_b,
  output logic [MAN_W:0]       sig_a,
  output logic [MAN_W:0]       sig_b,
  output logic [CLS_W-1:0]     cls_a,
  output logic [CLS_W-1:0]     cls_b
);

  localparam int unsigned XW = EXP_W + 2;
  localparam int unsigned SW = MAN_W + 1;

  norm_state_e       state_q;
  logic              sign_a_q, sign_b_q;
  logic [XW-1:0]     exp_a_q, exp_b_q;
  logic [SW-1:0]     sig_a_q, sig_b_q;
  logic [CLS_W-1:0]  cls_a_q, cls_b_q;

  logic              in_sign_a, in_sign_b;
  logic [EXP_W-1:0]  in_exp_a, in_exp_b;
  logic [MAN_W-1:0]  in_frac_a, in_frac_b;
  logic [CLS_W-1:0]  in_cls_a, in_cls_b;

  fp_classify #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_cls_a (
    .flp_i  (flp_a),
    .sign_o (in_sign_a),
    .exp_o  (in_exp_a),
    .frac_o (in_frac_a),
    .cls_o  (in_cls_a)
  );

  fp_classify #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_cls_b (
    .flp_i  (flp_b),
    .sign_o (in_sign_b),
    .exp_o  (in_exp_b),
    .frac_o (in_frac_b),
    .cls_o  (in_cls_b)
  );

  // Initial significand: hidden bit only for normals; specials keep the raw payload.
  function automatic logic [SW-1:0] cap_sig(input logic [CLS_W-1:0] cls,
                                            input logic [MAN_W-1:0] frac);
    if (cls[CLS_ZERO])   return '0;
    if (cls[CLS_NORMAL]) return {1'b1, frac};
    return {1'b0, frac};
  endfunction

  // Subnormals start at exponent 1 so each left shift maps to one decrement.
  function automatic logic [XW-1:0] cap_exp(input logic [CLS_W-1:0] cls,
                                            input logic [EXP_W-1:0] e);
    if (cls[CLS_ZERO]) return '0;
    if (cls[CLS_SUB])  return XW'(1);
    return {2'b00, e};
  endfunction

  logic          accept;
  logic          shift_a, shift_b;
  logic [SW-1:0] sig_a_nxt, sig_b_nxt;
  logic [XW-1:0] exp_a_nxt, exp_b_nxt;
  logic          norm_done;

  assign in_ready  = (state_q == StIdle) || ((state_q == StHold) && out_ready);
  assign out_valid = (state_q == StHold);
  assign accept    = in_valid && in_ready;

  assign shift_a   = cls_a_q[CLS_SUB] && !sig_a_q[SW-1];
  assign shift_b   = cls_b_q[CLS_SUB] && !sig_b_q[SW-1];
  assign sig_a_nxt = shift_a ? {sig_a_q[SW-2:0], 1'b0} : sig_a_q;
  assign sig_b_nxt = shift_b ? {sig_b_q[SW-2:0], 1'b0} : sig_b_q;
  assign exp_a_nxt = shift_a ? exp_a_q - XW'(1) : exp_a_q;
  assign exp_b_nxt = shift_b ? exp_b_q - XW'(1) : exp_b_q;
  // Judge completion on the post-shift values so HOLD is entered on the final shift.
  assign norm_done = (!cls_a_q[CLS_SUB] || sig_a_nxt[SW-1]) &&
                     (!cls_b_q[CLS_SUB] || sig_b_nxt[SW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      exp_a_q  <= '0;
      exp_b_q  <= '0;
      sig_a_q  <= '0;
      sig_b_q  <= '0;
      cls_a_q  <= '0;
      cls_b_q  <= '0;
    end else if (accept) begin
      sign_a_q <= in_sign_a;
      sign_b_q <= in_sign_b;
      exp_a_q  <= cap_exp(in_cls_a, in_exp_a);
      exp_b_q  <= cap_exp(in_cls_b, in_exp_b);
      sig_a_q  <= cap_sig(in_cls_a, in_frac_a);
      sig_b_q  <= cap_sig(in_cls_b, in_frac_b);
      cls_a_q  <= in_cls_a;
      cls_b_q  <= in_cls_b;
      state_q  <= (in_cls_a[CLS_SUB] || in_cls_b[CLS_SUB]) ? StNorm : StHold;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StIdle;
        StNorm: begin
          sig_a_q <= sig_a_nxt;
          sig_b_q <= sig_b_nxt;
          exp_a_q <= exp_a_nxt;
          exp_b_q <= exp_b_nxt;
          if (norm_done) state_q <= StHold;
        end
        StHold: if (out_ready) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sign_a = sign_a_q;
  assign sign_b = sign_b_q;
  assign exp_a  = exp_a_q;
  assign exp_b  = exp_b_q;
  assign sig_a  = sig_a_q;
  assign sig_b  = sig_b_q;
  assign cls_a  = cls_a_q;
  assign cls_b  = cls_b_q;

endmodule

// File: tb/tb_fp_unpack_norm.sv
// Bench for fp_unpack_norm at default widths: table of vectors with hand-derived
// expectations, a scoreboard queue popped on each output handshake, and sequences
// for backpressure, back-to-back streaming and reset during normalisation.
module tb_fp_unpack_norm;

  localparam logic [5:0] C_ZERO = 6'b100000;
  localparam logic [5:0] C_SUB  = 6'b010000;
  localparam logic [5:0] C_NORM = 6'b001000;
  localparam logic [5:0] C_INF  = 6'b000100;
  localparam logic [5:0] C_QNAN = 6'b000010;
  localparam logic [5:0] C_SNAN = 6'b000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] flp_a = '0;
  logic [31:0] flp_b = '0;
  logic        in_ready, out_valid, sign_a, sign_b;
  logic [9:0]  exp_a, exp_b;
  logic [23:0] sig_a, sig_b;
  logic [5:0]  cls_a, cls_b;

  fp_unpack_norm #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flp_a     (flp_a),
    .flp_b     (flp_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .sig_a     (sig_a),
    .sig_b     (sig_b),
    .cls_a     (cls_a),
    .cls_b     (cls_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a, b;
    logic        sa, sb;
    logic [9:0]  ea, eb;
    logic [23:0] ga, gb;
    logic [5:0]  ca, cb;
    int          lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  exp_t sbq[$];
  int   pop_cyc[$];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   head_seen = 1'b0;

  logic [81:0] dut_out;
  assign dut_out = {sign_a, sign_b, exp_a, exp_b, sig_a, sig_b, cls_a, cls_b};

  function automatic logic [81:0] pack(input vec_t v);
    return {v.sa, v.sb, v.ea, v.eb, v.ga, v.gb, v.ca, v.cb};
  endfunction

  function automatic vec_t mk(input logic [31:0] a, b, input logic sa, sb,
                              input logic [9:0] ea, eb, input logic [23:0] ga, gb,
                              input logic [5:0] ca, cb, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb;
    v.ga = ga; v.gb = gb; v.ca = ca; v.cb = cb; v.lat = lat;
    return v;
  endfunction

  // Streaming pairs: both operands normal, so expectations follow directly from the fields.
  function automatic vec_t gen(input int i);
    logic [7:0]  e;
    logic [22:0] f;
    e = 8'(60 + i * 17);
    f = 23'(i * 40503 + 7);
    return mk({1'b0, e, f}, {1'b1, e + 8'd1, ~f}, 1'b0, 1'b1, {2'b00, e},
              {2'b00, e + 8'd1}, {1'b1, f}, {1'b1, ~f}, C_NORM, C_NORM, 1);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: samples 2 time units after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got out_valid=1 expected no pending pair");
        end else begin
          if (!head_seen) begin
            check($sformatf("latency a=%h", sbq[0].v.a), 128'(cyc - sbq[0].acc),
                  128'(sbq[0].v.lat));
            head_seen = 1'b1;
          end
          if (out_ready) begin
            check($sformatf("data a=%h b=%h", sbq[0].v.a, sbq[0].v.b), 128'(dut_out),
                  128'(pack(sbq[0].v)));
            pop_cyc.push_back(cyc);
            void'(sbq.pop_front());
            head_seen = 1'b0;
          end
        end
      end
    end
  end

  // Called at a falling edge; returns at a later falling edge with in_valid low.
  task automatic send(input vec_t v, input bit push);
    int k;
    in_valid = 1'b1;
    flp_a = v.a;
    flp_b = v.b;
    #1;
    for (k = 0; k < 300 && !in_ready; k++) begin
      @(negedge clk);
      #1;
    end
    if (!in_ready) begin
      check("accept_timeout", 128'(in_ready), 128'(1));
    end else if (push) begin
      sbq.push_back('{v: v, acc: cyc});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sbq.size() != 0; k++) @(negedge clk);
    check("drain", 128'(sbq.size()), 128'(0));
  endtask

  vec_t tbl[8];
  vec_t sub1;
  int   first_pop;

  initial begin
    tbl[0] = mk(32'h3F800000, 32'h40000000, 0, 0, 10'd127, 10'd128, 24'h800000, 24'h800000,
                C_NORM, C_NORM, 1);
    tbl[1] = mk(32'h00000001, 32'h3F800000, 0, 0, 10'h3EA, 10'd127, 24'h800000, 24'h800000,
                C_SUB, C_NORM, 24);
    tbl[2] = mk(32'h7F800000, 32'h7FA00000, 0, 0, 10'd255, 10'd255, 24'h000000, 24'h200000,
                C_INF, C_SNAN, 1);
    tbl[3] = mk(32'h80000000, 32'h3F800000, 1, 0, 10'd0, 10'd127, 24'h000000, 24'h800000,
                C_ZERO, C_NORM, 1);
    tbl[4] = mk(32'hFFC00001, 32'h00400000, 1, 0, 10'd255, 10'd0, 24'h400001, 24'h800000,
                C_QNAN, C_SUB, 2);
    tbl[5] = mk(32'h00000003, 32'h00100000, 0, 0, 10'h3EB, 10'h3FE, 24'hC00000, 24'h800000,
                C_SUB, C_SUB, 23);
    tbl[6] = mk(32'h7F7FFFFF, 32'h00800000, 0, 0, 10'd254, 10'd1, 24'hFFFFFF, 24'h800000,
                C_NORM, C_NORM, 1);
    tbl[7] = mk(32'h807FFFFF, 32'h00000000, 1, 0, 10'd0, 10'd0, 24'hFFFFFE, 24'h000000,
                C_SUB, C_ZERO, 2);
    sub1 = tbl[1];

    // Reset state
    #2;
    check("reset in_ready", 128'(in_ready), 128'(1));
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset outputs", 128'(dut_out), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors
    for (int i = 0; i < 8; i++) send(tbl[i], 1'b1);
    drain();

    // Backpressure: hold first pair for 5 cycles while a second one waits
    out_ready = 1'b0;
    send(tbl[0], 1'b1);
    in_valid = 1'b1;
    flp_a = tbl[3].a;
    flp_b = tbl[3].b;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp[%0d] in_ready", k), 128'(in_ready), 128'(0));
      check($sformatf("bp[%0d] out_valid", k), 128'(out_valid), 128'(1));
      check($sformatf("bp[%0d] held", k), 128'(dut_out), 128'(pack(tbl[0])));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 128'(in_ready), 128'(1));
    sbq.push_back('{v: tbl[3], acc: cyc});
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Back-to-back stream of 8 normal pairs
    first_pop = pop_cyc.size();
    for (int i = 0; i < 8; i++) send(gen(i), 1'b1);
    drain();
    check("stream pops", 128'(pop_cyc.size() - first_pop), 128'(8));
    if (pop_cyc.size() == first_pop + 8)
      check("stream consecutive", 128'(pop_cyc[first_pop+7] - pop_cyc[first_pop]), 128'(7));

    // Reset during normalisation abandons the pair
    send(sub1, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    check("norm out_valid", 128'(out_valid), 128'(0));
    check("norm in_ready", 128'(in_ready), 128'(0));
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 128'(out_valid), 128'(0));
    check("midreset in_ready", 128'(in_ready), 128'(1));
    check("midreset outputs", 128'(dut_out), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(tbl[6], 1'b1);
    drain();
    repeat (3) @(negedge clk);
    #1;
    check("final out_valid", 128'(out_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_unpack_norm.md
# fp_unpack_norm

Parametrised, handshaked operand front-end for the floating-point divider (and other FP units). It accepts two packed IEEE-754-style operands, splits sign, exponent and significand, and classifies each operand. It restores the hidden bit and normalises subnormal significands with an iterative one-bit-per-cycle shifter. The result is a registered, normalised operand pair with a valid/ready handshake for the downstream datapath.

## Interface

- EXP_W, default 8: exponent field width.
- MAN_W, default 23: stored fraction width. Operand width is 1+EXP_W+MAN_W.
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operand pair offered.
- in_ready, output, 1: block can accept a pair this cycle.
- flp_a, input, 1+EXP_W+MAN_W: packed operand A.
- flp_b, input, 1+EXP_W+MAN_W: packed operand B.
- out_valid, output, 1: normalised pair available.
- out_ready, input, 1: downstream accepts the pair.
- sign_a / sign_b, output, 1 each: sign bits.
- exp_a / exp_b, output, EXP_W+2 each: signed, biased, extended exponent. The value can go below 1 after normalisation.
- sig_a / sig_b, output, MAN_W+1 each: significand with explicit hidden bit. MSB is set for every normalised finite nonzero value.
- cls_a / cls_b, output, 6 each: one-hot class, bit order {zero, subnormal, normal, inf, qnan, snan}.

## Operation

- States:
  - IDLE: empty.
  - NORM: shifting.
  - HOLD: result valid.
- in_ready = (state==IDLE) || (state==HOLD && out_ready).
- out_valid = (state==HOLD).
- Accept (in_valid && in_ready) captures both operands into registers.
- Classification per operand, with exponent field E and fraction F:
  - zero: E==0 and F==0.
  - subnormal: E==0 and F!=0.
  - normal: 0<E<all-ones.
  - inf: E==all-ones and F==0.
  - qnan: E==all-ones and F MSB==1.
  - snan: E==all-ones, F MSB==0, F!=0.
- Captured values per class:
  - normal: sig={1,F}, exp=E zero-extended.
  - subnormal: sig={0,F}, exp=1.
  - zero: sig=0, exp=0.
  - inf/NaN: sig={0,F}, exp=E zero-extended. Never shifted; the NaN payload is preserved.
- After accept: go to NORM if either operand is subnormal, else HOLD.
- Each NORM cycle, for every operand that is subnormal with sig MSB==0: sig <<= 1, exp -= 1 (two's complement, EXP_W+2 bits).
- Exit NORM to HOLD on the cycle in which both operands have sig MSB==1 or are non-subnormal.
- cls outputs keep the original class (subnormal stays flagged after normalisation).
- HOLD with out_ready: if in_valid, accept the new pair (IDLE-equivalent transition); else go to IDLE.
- HOLD without out_ready: all outputs held stable.
- Inputs are ignored whenever in_ready==0.

## Timing

- Reset (asynchronous assert, synchronous release): state=IDLE, in_ready=1, out_valid=0, and all data/cls outputs 0.
- Reset asserted mid-NORM or mid-HOLD abandons the pair immediately. No output is produced for it.
- Latency from the accept edge to out_valid:
  - 1 cycle if neither operand is subnormal.
  - 1+N cycles otherwise, where N = max over subnormal operands of (leading zeros of F)+1.
  - Maximum N = MAN_W (F=1).
- Throughput:
  - 1 pair/cycle for normal/special operands with out_ready held high.
  - Subnormals stall input for N cycles.
- Simultaneous pop and push in HOLD: the new pair is captured on the same edge; out_valid stays high only if the new pair needs no normalisation, otherwise it drops for N cycles.

## Structure

- Shared package fp_pkg holds:
  - the class bit indices (CLS_ZERO..CLS_SNAN) and class width;
  - state encoding typedef;
  - helper constants for all-ones exponent.
- One sub-module, fp_classify: purely combinational, instantiated twice. Input is one packed operand; outputs are sign, E, F and one-hot class.
- The top level owns the FSM, the operand registers and the per-operand shift/decrement logic.

## Test plan

- Normal pair, defaults: A=0x3F800000, B=0x40000000, out_ready=1 -> out_valid one cycle after accept. exp_a=127, exp_b=128, sig_a=sig_b=0x800000, cls=normal.
- Subnormal: A=0x00000001, B=0x3F800000 -> out_valid 24 cycles after accept. sig_a=0x800000, exp_a=-22 (10-bit 0x3EA), cls_a=subnormal, B unchanged.
- Specials: A=0x7F800000, B=0x7FA00000 -> latency 1. cls_a=inf, cls_b=snan, sig_b=0x200000, exp_b=255. Then zero A=0x80000000 -> sign_a=1, cls zero, sig 0.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0. Release -> pair popped and the next pair accepted on the same edge.
- Back-to-back: 8 normal pairs with in_valid and out_ready continuously high -> 8 results on 8 consecutive cycles, in order.
- Reset mid-NORM: assert rst_n low during the A=0x00000001 normalisation -> immediate IDLE, out_valid=0, outputs 0. The next accepted normal pair completes with latency 1.
